// File: rtl/trap_unit.sv
// Machine-mode trap/mret sequencer: prioritises interrupts and exceptions at commit, drives CSR writes and the fetch redirect.
// Latency: interrupt lines are visible SYNC_STAGES cycles after they change; each trap or mret takes 3 cycles (detect, write, redirect).
// Backpressure: there is no handshake; FLUSH_SM/STALL_SM hold the pipeline while a sequence runs, and commit inputs are ignored outside IDLE.
module trap_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        COMMIT_VALID_SM,
  input  logic [31:0] COMMIT_PC_SM,
  input  logic [31:0] COMMIT_INSTR_SM,
  input  logic [8:0]  EXC_FLAGS_SM,
  input  logic [31:0] FAULT_ADR_SM,
  input  logic        MRET_SM,
  input  logic [11:0] PIPE_CSR_WADR_SM,
  input  logic [31:0] PIPE_CSR_WDATA_SM,
  input  logic        PIPE_CSR_ENABLE_SM,
  input  logic        IRQ_EXT,
  input  logic        IRQ_TIMER,
  input  logic        IRQ_SOFT,
  input  logic [31:0] MSTATUS_RC,
  input  logic [31:0] MTVEC_VALUE_RC,
  input  logic [31:0] MIE_VALUE_RC,
  input  logic [31:0] MEPC_SC,
  output logic [11:0] CSR_WADR_SM,
  output logic [31:0] CSR_WDATA_SM,
  output logic        CSR_ENABLE_SM,
  output logic        EXCEPTION_SM,
  output logic [31:0] MSTATUS_WDATA_SM,
  output logic [31:0] MIP_WDATA_SM,
  output logic [31:0] MEPC_WDATA_SM,
  output logic [31:0] MCAUSE_WDATA_SM,
  output logic [31:0] MTVAL_WDATA_SM,
  output logic        FLUSH_SM,
  output logic        STALL_SM,
  output logic        REDIRECT_VALID_SM,
  output logic [31:0] REDIRECT_PC_SM
);

  typedef enum logic [1:0] {IDLE, TRAP_WR, MRET_WR, REDIRECT} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ext_sync, tim_sync, soft_sync;
  logic                   ext_s, tim_s, soft_s;
  logic [31:0]            pend, irq_active;
  logic                   is_idle, intr_take, exc_take, trap_take, mret_take;
  logic [3:0]             intr_code, exc_code, trap_code;
  logic [31:0]            trap_mcause, trap_mtval, trap_mstatus, mret_mstatus;
  logic [31:0]            tvec_base, tvec_target;

  // Registered trap/mret state
  logic [31:0] mstatus_q, mepc_q, mcause_q, mtval_q, mret_mstatus_q;
  logic        intr_q, mret_q;
  logic [3:0]  code_q;
  logic        exception_q, flush_q, redirect_q;

  // Two-or-more flop synchronisers on each asynchronous interrupt line
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_sync  <= '0;
      tim_sync  <= '0;
      soft_sync <= '0;
    end else begin
      ext_sync  <= {ext_sync[SYNC_STAGES-2:0], IRQ_EXT};
      tim_sync  <= {tim_sync[SYNC_STAGES-2:0], IRQ_TIMER};
      soft_sync <= {soft_sync[SYNC_STAGES-2:0], IRQ_SOFT};
    end
  end

  assign ext_s  = ext_sync[SYNC_STAGES-1];
  assign tim_s  = tim_sync[SYNC_STAGES-1];
  assign soft_s = soft_sync[SYNC_STAGES-1];

  // Pending vector: external at bit 11, timer at bit 7, software at bit 3
  assign pend         = {20'b0, ext_s, 3'b0, tim_s, 3'b0, soft_s, 3'b0};
  assign MIP_WDATA_SM = pend;
  assign irq_active   = pend & MIE_VALUE_RC;

  assign is_idle   = (state == IDLE);
  assign intr_take = is_idle && COMMIT_VALID_SM && MSTATUS_RC[3] && (irq_active != 32'b0);
  assign exc_take  = is_idle && COMMIT_VALID_SM && !intr_take && (EXC_FLAGS_SM != 9'b0);
  assign trap_take = intr_take || exc_take;
  assign mret_take = is_idle && COMMIT_VALID_SM && MRET_SM && !intr_take && (EXC_FLAGS_SM == 9'b0);

  // Cause selection: fixed priority among interrupts and among exception flags
  always_comb begin
    intr_code = 4'd7;
    if (irq_active[11])     intr_code = 4'd11;
    else if (irq_active[3]) intr_code = 4'd3;

    exc_code = 4'd0;
    if (EXC_FLAGS_SM[1])      exc_code = 4'd1;
    else if (EXC_FLAGS_SM[0]) exc_code = 4'd0;
    else if (EXC_FLAGS_SM[2]) exc_code = 4'd2;
    else if (EXC_FLAGS_SM[3]) exc_code = 4'd3;
    else if (EXC_FLAGS_SM[8]) exc_code = 4'd11;
    else if (EXC_FLAGS_SM[6]) exc_code = 4'd6;
    else if (EXC_FLAGS_SM[4]) exc_code = 4'd4;
    else if (EXC_FLAGS_SM[7]) exc_code = 4'd7;
    else if (EXC_FLAGS_SM[5]) exc_code = 4'd5;
  end

  // Trap write data derived from the committing instruction and current mstatus
  always_comb begin
    trap_code   = intr_take ? intr_code : exc_code;
    trap_mcause = intr_take ? {1'b1, 27'b0, intr_code} : {28'b0, exc_code};

    trap_mtval = 32'b0;
    if (!intr_take) begin
      case (exc_code)
        4'd0, 4'd1, 4'd4, 4'd5, 4'd6, 4'd7: trap_mtval = FAULT_ADR_SM;
        4'd2:                               trap_mtval = COMMIT_INSTR_SM;
        default:                            trap_mtval = 32'b0;
      endcase
    end

    trap_mstatus        = MSTATUS_RC;
    trap_mstatus[7]     = MSTATUS_RC[3];
    trap_mstatus[3]     = 1'b0;
    trap_mstatus[12:11] = 2'b11;

    mret_mstatus        = MSTATUS_RC;
    mret_mstatus[3]     = MSTATUS_RC[7];
    mret_mstatus[7]     = 1'b1;
    mret_mstatus[12:11] = 2'b11;
  end

  // Sequencer: captures trap/mret data on leaving IDLE and walks write -> redirect -> idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mstatus_q      <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mret_mstatus_q <= '0;
      intr_q         <= 1'b0;
      mret_q         <= 1'b0;
      code_q         <= '0;
      exception_q    <= 1'b0;
      flush_q        <= 1'b0;
      redirect_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (trap_take) begin
            state       <= TRAP_WR;
            mstatus_q   <= trap_mstatus;
            mepc_q      <= COMMIT_PC_SM;
            mcause_q    <= trap_mcause;
            mtval_q     <= trap_mtval;
            intr_q      <= intr_take;
            code_q      <= trap_code;
            mret_q      <= 1'b0;
            exception_q <= 1'b1;
            flush_q     <= 1'b1;
          end else if (mret_take) begin
            state          <= MRET_WR;
            mret_mstatus_q <= mret_mstatus;
            mret_q         <= 1'b1;
            flush_q        <= 1'b1;
          end
        end
        TRAP_WR: begin
          state       <= REDIRECT;
          exception_q <= 1'b0;
          mstatus_q   <= '0;
          mepc_q      <= '0;
          mcause_q    <= '0;
          mtval_q     <= '0;
          redirect_q  <= 1'b1;
        end
        MRET_WR: begin
          state      <= REDIRECT;
          redirect_q <= 1'b1;
        end
        REDIRECT: begin
          state      <= IDLE;
          redirect_q <= 1'b0;
          flush_q    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign EXCEPTION_SM     = exception_q;
  assign MSTATUS_WDATA_SM = mstatus_q;
  assign MEPC_WDATA_SM    = mepc_q;
  assign MCAUSE_WDATA_SM  = mcause_q;
  assign MTVAL_WDATA_SM   = mtval_q;
  assign FLUSH_SM         = flush_q;
  assign STALL_SM         = flush_q;

  // Redirect target uses live mtvec/mepc so writes retired just before the trap are seen
  assign tvec_base   = {MTVEC_VALUE_RC[31:2], 2'b00};
  assign tvec_target = (intr_q && (MTVEC_VALUE_RC[1:0] == 2'b01))
                       ? tvec_base + {26'b0, code_q, 2'b00} : tvec_base;

  assign REDIRECT_VALID_SM = redirect_q;
  assign REDIRECT_PC_SM    = redirect_q ? (mret_q ? MEPC_SC : tvec_target) : 32'b0;

  // CSR write port arbitration: pipeline passthrough in IDLE unless trapping, mstatus restore in MRET_WR
  always_comb begin
    CSR_ENABLE_SM = 1'b0;
    CSR_WADR_SM   = 12'b0;
    CSR_WDATA_SM  = 32'b0;
    if (state == MRET_WR) begin
      CSR_ENABLE_SM = 1'b1;
      CSR_WADR_SM   = 12'h300;
      CSR_WDATA_SM  = mret_mstatus_q;
    end else if (is_idle && !trap_take && PIPE_CSR_ENABLE_SM) begin
      CSR_ENABLE_SM = 1'b1;
      CSR_WADR_SM   = PIPE_CSR_WADR_SM;
      CSR_WDATA_SM  = PIPE_CSR_WDATA_SM;
    end
  end

endmodule
